// File: rtl/multdiv_sequencer.sv
// Multi-cycle signed multiply/divide engine for the execute stage.
// Iterates on operand magnitudes (shift-add multiply, restoring divide),
// applies the sign on the final cycle, and reports overflow or divide-by-zero
// as an rstatus code written to r30.
module multdiv_sequencer #(
  parameter int WIDTH         = 32,
  parameter int ITER          = 32,
  parameter int MULT_EXC_CODE = 4,
  parameter int DIV_EXC_CODE  = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [4:0]       rd,
  output logic             stall,
  output logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       wb_reg,
  output logic             exception
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Mult: {partial product, remaining multiplier}. Div: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Mult: multiplicand magnitude. Div: divisor magnitude.
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic               dz_q, dz_d;
  logic [4:0]         rd_q, rd_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [4:0]         wb_q, wb_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mstep;
  logic [2*WIDTH-1:0] dsh;
  logic [WIDTH:0]     dtrial;
  logic [2*WIDTH-1:0] dstep;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic               ovf;

  // One iteration of either algorithm plus the sign fix-up of its outcome.
  always_comb begin
    abs_a  = operandA[WIDTH-1] ? -operandA : operandA;
    abs_b  = operandB[WIDTH-1] ? -operandB : operandB;
    // Carry out of the partial-product add lands in the top bit after the shift.
    msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    mstep  = {msum, acc_q[WIDTH-1:1]};
    dsh    = {acc_q[2*WIDTH-2:0], 1'b0};
    dtrial = {1'b0, dsh[2*WIDTH-1:WIDTH]} - {1'b0, opd_q};
    dstep  = dtrial[WIDTH] ? dsh : {dtrial[WIDTH-1:0], dsh[WIDTH-1:1], 1'b1};
    step   = div_q ? dstep : mstep;
    prod   = neg_q ? -step : step;
    quot   = neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
    ovf    = !(&prod[2*WIDTH-1:WIDTH-1]) && (|prod[2*WIDTH-1:WIDTH-1]);
  end

  // Next-state, datapath update and stall.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opd_d    = opd_q;
    div_d    = div_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    rd_d     = rd_q;
    result_d = result_q;
    wb_d     = wb_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    stall    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          stall   = 1'b1;
          state_d = S_BUSY;
          cnt_d   = CW'(ITER - 1);
          div_d   = is_div;
          rd_d    = rd;
          neg_d   = operandA[WIDTH-1] ^ operandB[WIDTH-1];
          dz_d    = (operandB == '0);
          opd_d   = is_div ? abs_b : abs_a;
          acc_d   = {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        acc_d = step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          // Result is formed from this cycle's final iteration, not acc_q.
          state_d = S_DONE;
          cnt_d   = '0;
          rdy_d   = 1'b1;
          if (div_q) begin
            if (dz_q) begin
              result_d = WIDTH'(DIV_EXC_CODE);
              wb_d     = 5'd30;
              exc_d    = 1'b1;
            end else begin
              result_d = quot;
              wb_d     = rd_q;
              exc_d    = 1'b0;
            end
          end else begin
            if (ovf) begin
              result_d = WIDTH'(MULT_EXC_CODE);
              wb_d     = 5'd30;
              exc_d    = 1'b1;
            end else begin
              result_d = prod[WIDTH-1:0];
              wb_d     = rd_q;
              exc_d    = 1'b0;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opd_q    <= '0;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      wb_q     <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opd_q    <= opd_d;
      div_q    <= div_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      wb_q     <= wb_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign result_ready = rdy_q;
  assign result       = result_q;
  assign wb_reg       = wb_q;
  assign exception    = exc_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed-vector bench for multdiv_sequencer with hand-computed results.
module tb_multdiv_sequencer;

  localparam int ITER = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_div = 1'b0;
  logic [31:0] operandA = '0;
  logic [31:0] operandB = '0;
  logic [4:0]  rd = '0;
  logic        stall;
  logic        result_ready;
  logic [31:0] result;
  logic [4:0]  wb_reg;
  logic        exception;

  int checks = 0;
  int errors = 0;

  multdiv_sequencer #(
    .WIDTH(32),
    .ITER(ITER),
    .MULT_EXC_CODE(4),
    .DIV_EXC_CODE(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .is_div(is_div),
    .operandA(operandA),
    .operandB(operandB),
    .rd(rd),
    .stall(stall),
    .result_ready(result_ready),
    .result(result),
    .wb_reg(wb_reg),
    .exception(exception)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic div, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
    start    = 1'b1;
    is_div   = div;
    operandA = a;
    operandB = b;
    rd       = r;
  endtask

  // Called at a negedge with start already driven; returns at the DONE negedge.
  task automatic wait_result(input string tag, input logic [31:0] er, input logic [4:0] ew,
                             input logic ee, input bit hold);
    int n;
    bit stall_ok;
    #1 check_eq({tag, "_stall_start"}, {31'd0, stall}, 32'd1);
    @(posedge clock);
    #1;
    if (!hold) start = 1'b0;
    n = 0;
    stall_ok = 1'b1;
    @(negedge clock);
    while (!result_ready && n < ITER + 8) begin
      if (!stall) stall_ok = 1'b0;
      if (hold) begin
        operandA = $urandom;
        operandB = $urandom;
        rd       = 5'($urandom);
        is_div   = 1'($urandom);
      end
      n++;
      @(negedge clock);
    end
    check_eq({tag, "_latency"}, n, ITER);
    check_eq({tag, "_stall_busy"}, {31'd0, stall_ok}, 32'd1);
    check_eq({tag, "_result"}, result, er);
    check_eq({tag, "_wb_reg"}, {27'd0, wb_reg}, {27'd0, ew});
    check_eq({tag, "_exception"}, {31'd0, exception}, {31'd0, ee});
    check_eq({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    int pulses;
    #12;
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_ready", {31'd0, result_ready}, 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_wb", {27'd0, wb_reg}, 32'd0);
    check_eq("rst_exc", {31'd0, exception}, 32'd0);
    reset = 1'b0;

    @(negedge clock); drive(1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    wait_result("mul_basic", 32'hFFFF_FFEB, 5'd5, 1'b0, 1'b0);
    @(negedge clock); check_eq("mul_basic_one_pulse", {31'd0, result_ready}, 32'd0);

    @(negedge clock); drive(1'b0, 32'h4000_0000, 32'd4, 5'd6);
    wait_result("mul_ovf_pos", 32'd4, 5'd30, 1'b1, 1'b0);
    @(negedge clock); drive(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 5'd7);
    wait_result("mul_ovf_min", 32'd4, 5'd30, 1'b1, 1'b0);
    @(negedge clock); drive(1'b0, 32'h7FFF_FFFF, 32'd2, 5'd4);
    wait_result("mul_ovf_max2", 32'd4, 5'd30, 1'b1, 1'b0);
    @(negedge clock); drive(1'b0, 32'hFFFF_0000, 32'h0000_8000, 5'd12);
    wait_result("mul_min_exact", 32'h8000_0000, 5'd12, 1'b0, 1'b0);
    @(negedge clock); drive(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    wait_result("mul_rd0", 32'd1, 5'd0, 1'b0, 1'b0);

    @(negedge clock); drive(1'b1, 32'hFFFF_FFF9, 32'd2, 5'd8);
    wait_result("div_neg", 32'hFFFF_FFFD, 5'd8, 1'b0, 1'b0);
    @(negedge clock); drive(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    wait_result("div_min", 32'h8000_0000, 5'd10, 1'b0, 1'b0);
    @(negedge clock); drive(1'b1, 32'd100, 32'hFFFF_FFF9, 5'd13);
    wait_result("div_negdiv", 32'hFFFF_FFF2, 5'd13, 1'b0, 1'b0);
    @(negedge clock); drive(1'b1, 32'd123, 32'd0, 5'd9);
    wait_result("div_zero", 32'd5, 5'd30, 1'b1, 1'b0);

    // Operands and rd scrambled throughout BUSY with start held high.
    @(negedge clock); drive(1'b1, 32'd1000, 32'd10, 5'd11);
    wait_result("hold", 32'd100, 5'd11, 1'b0, 1'b1);
    drive(1'b0, 32'd6, 32'd7, 5'd3);
    @(negedge clock);
    check_eq("hold_one_pulse", {31'd0, result_ready}, 32'd0);
    wait_result("hold_next", 32'd42, 5'd3, 1'b0, 1'b0);

    // Abort an operation in its tenth BUSY cycle.
    @(negedge clock); drive(1'b0, 32'd5, 32'd6, 5'd12);
    #1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (10) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check_eq("abort_stall", {31'd0, stall}, 32'd0);
    check_eq("abort_ready", {31'd0, result_ready}, 32'd0);
    check_eq("abort_result", result, 32'd0);
    check_eq("abort_wb", {27'd0, wb_reg}, 32'd0);
    check_eq("abort_exc", {31'd0, exception}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    repeat (ITER + 8) begin
      @(negedge clock);
      if (result_ready) pulses++;
    end
    check_eq("abort_no_result", pulses, 0);
    @(negedge clock); drive(1'b0, 32'hFFFF_FFF6, 32'd10, 5'd14);
    wait_result("post_abort", 32'hFFFF_FF9C, 5'd14, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
